pop_fitness_eval: RTL and testbench
===================================

Name: pop_fitness_eval

Overview:
Downstream consumer of the population-initialisation stage. It captures the flat 7500-bit population vector on a start pulse and walks it one chromosome per clock. For each chromosome it emits a fitness value, and it accumulates total fitness and the best individual, which the roulette-selection stage uses. It uses the same start/done single-pulse handshake as the rest of the GA pipeline.

Parameters:
NUM_CHROM, 250, number of individuals in the population
CHROM_W, 30, bits per individual (NUM_CHROM*CHROM_W = 7500)
GENE_W, 5, bits per gene; CHROM_W/GENE_W = 6 genes per individual

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
start  input  1  begin evaluation; sampled only in IDLE
population  input  7500  flat population; individual i = population[7499-30*i -: 30]
busy  output  1  high in LOAD and EVAL
fit_valid  output  1  registered; fit_index/fit_value valid this cycle
fit_index  output  8  index of individual just evaluated
fit_value  output  8  fitness of that individual
best_index  output  8  index of highest-fitness individual
best_fitness  output  8  fitness of best_index
total_fitness  output  16  sum of all fitness values
done  output  1  high for exactly one cycle when results are final

Behaviour:
- Fitness: unsigned sum of the six 5-bit genes of an individual. Range 0..186, 8 bits. Total fitness max 46500, 16 bits, no overflow possible.
- States:
  - IDLE: start=1 -> LOAD, else stay IDLE.
  - LOAD: pop_reg<=population; counter<=0; best_index, best_fitness, total_fitness cleared to 0; -> EVAL.
  - EVAL: one individual per edge, taken from the top CHROM_W bits of pop_reg. pop_reg shifts left by CHROM_W. counter increments. When counter==NUM_CHROM-1 -> DONE, else stay EVAL.
  - DONE: done=1 (combinational from state); -> IDLE unconditionally.
- Per EVAL edge: fit_valid<=1, fit_index<=counter, fit_value<=f. total_fitness<=total_fitness+f.
- Best update:
  - If f > best_fitness, then best_fitness<=f and best_index<=counter.
  - Strict compare: on a tie the lowest index wins. An all-zero population gives best_index=0.
- fit_valid is 0 on every edge outside EVAL. It is high for exactly NUM_CHROM consecutive cycles.
- Latency, counting the edge that samples start as edge 0:
  - LOAD after edge 0; EVAL from edge 1.
  - Individuals 0..249 are evaluated on edges 2..251; fit_valid is high in the cycles following edges 2..251.
  - DONE after edge 251, so done is high in the cycle following edge 251. That is 252 cycles after start.
  - Back in IDLE after edge 252.
- start is ignored in LOAD, EVAL and DONE; there is no restart mid-run. start held high continuously re-triggers from IDLE, so runs are back-to-back with one IDLE cycle between them.
- population is sampled only in LOAD. Changes after LOAD do not affect the run.
- best_index, best_fitness and total_fitness hold their final values from DONE until the next LOAD clears them.
- Reset (any state, including mid-EVAL): state=IDLE, counter=0, pop_reg=0. All outputs are 0: busy, fit_valid, fit_index, fit_value, best_*, total_fitness, done. Reset has priority over start.
- Internal widths: counter 8 bits (0..249). The gene adder tree is combinational on pop_reg top bits, giving a single-cycle path.

Test Plan:
- Population all zeros, start pulse -> 250 fit_valid cycles each with fit_value=0; done 252 cycles after start; best_index=0, best_fitness=0, total_fitness=0.
- Population all ones -> every fit_value=186; total_fitness=46500; best_index=0 (tie rule); best_fitness=186.
- All zeros except individual 137, with genes 31,31,0,0,1,2 -> fit_value[137]=65, all others 0; best_index=137, best_fitness=65, total_fitness=65. Also check fit_index increments 0..249 in order.
- Individuals 10 and 200 both at fitness 100, all others 0 -> best_index=10, total_fitness=200.
- Assert rst during EVAL at counter=120 -> next cycle all outputs 0, state IDLE. A new start then completes a full 250-entry run with correct totals.
- Pulse start again during EVAL and during DONE -> ignored, exactly one done pulse. Holding start high for two runs -> two done pulses 253 cycles apart. Changing population after LOAD -> results reflect the captured value only.

Source files
------------

// File: rtl/pop_fitness_eval.sv
// Walks a captured population one chromosome per clock, emitting per-individual
// fitness (sum of genes) and accumulating total fitness and the best individual.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start
// S_LOAD | capture population, clear counter and accumulators
// S_EVAL | evaluate one individual per clock from the top of r_pop
// S_DONE | results final; done asserted for this one cycle
module pop_fitness_eval #(
    parameter int NUM_CHROM = 250,
    parameter int CHROM_W   = 30,
    parameter int GENE_W    = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_CHROM*CHROM_W-1:0]   population,
    output logic                           busy,
    output logic                           fit_valid,
    output logic [7:0]                     fit_index,
    output logic [7:0]                     fit_value,
    output logic [7:0]                     best_index,
    output logic [7:0]                     best_fitness,
    output logic [15:0]                    total_fitness,
    output logic                           done
);

    localparam int          POP_W  = NUM_CHROM * CHROM_W;
    localparam int          N_GENE = CHROM_W / GENE_W;
    localparam logic [7:0]  LAST   = 8'(NUM_CHROM - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EVAL, S_DONE} state_t;

    state_t             r_state;
    logic [POP_W-1:0]   r_pop;
    logic [7:0]         r_cnt;
    logic               r_fit_valid;
    logic [7:0]         r_fit_index;
    logic [7:0]         r_fit_value;
    logic [7:0]         r_best_index;
    logic [7:0]         r_best_fitness;
    logic [15:0]        r_total;
    logic [7:0]         w_fit;

    // Adder tree over the genes of the chromosome currently at the top of r_pop.
    always_comb begin
        w_fit = '0;
        for (int g = 0; g < N_GENE; g++) begin
            w_fit = w_fit + 8'(r_pop[POP_W-1-GENE_W*g -: GENE_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_pop          <= '0;
            r_cnt          <= '0;
            r_fit_valid    <= 1'b0;
            r_fit_index    <= '0;
            r_fit_value    <= '0;
            r_best_index   <= '0;
            r_best_fitness <= '0;
            r_total        <= '0;
        end else begin
            r_fit_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_pop          <= population;
                    r_cnt          <= '0;
                    r_best_index   <= '0;
                    r_best_fitness <= '0;
                    r_total        <= '0;
                    r_state        <= S_EVAL;
                end
                S_EVAL: begin
                    r_fit_valid <= 1'b1;
                    r_fit_index <= r_cnt;
                    r_fit_value <= w_fit;
                    r_total     <= r_total + 16'(w_fit);
                    // Strict compare so the lowest index keeps a tie.
                    if (w_fit > r_best_fitness) begin
                        r_best_fitness <= w_fit;
                        r_best_index   <= r_cnt;
                    end
                    r_pop <= r_pop << CHROM_W;
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == LAST) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy          = (r_state == S_LOAD) || (r_state == S_EVAL);
    assign done          = (r_state == S_DONE);
    assign fit_valid     = r_fit_valid;
    assign fit_index     = r_fit_index;
    assign fit_value     = r_fit_value;
    assign best_index    = r_best_index;
    assign best_fitness  = r_best_fitness;
    assign total_fitness = r_total;

endmodule

// File: tb/tb_pop_fitness_eval.sv
// Bench for pop_fitness_eval: table of population patterns with expected
// best/total, a queue of expected per-individual fitness, plus reset/start corner cases.
module tb_pop_fitness_eval;

    localparam int NUM_CHROM = 250;
    localparam int CHROM_W   = 30;
    localparam int GENE_W    = 5;
    localparam int POP_W     = NUM_CHROM * CHROM_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [POP_W-1:0]  population;
    logic              busy, fit_valid, done;
    logic [7:0]        fit_index, fit_value, best_index, best_fitness;
    logic [15:0]       total_fitness;

    pop_fitness_eval #(.NUM_CHROM(NUM_CHROM), .CHROM_W(CHROM_W), .GENE_W(GENE_W)) dut (
        .clk(clk), .rst(rst), .start(start), .population(population),
        .busy(busy), .fit_valid(fit_valid), .fit_index(fit_index), .fit_value(fit_value),
        .best_index(best_index), .best_fitness(best_fitness),
        .total_fitness(total_fitness), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int bi;
        int bf;
        int tot;
    } vec_t;

    typedef struct {
        int idx;
        int val;
    } exp_t;

    vec_t vecs[4];
    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int fit_of(input logic [POP_W-1:0] p, input int i);
        logic [CHROM_W-1:0] c;
        int s;
        c = p[POP_W-1-CHROM_W*i -: CHROM_W];
        s = 0;
        for (int g = 0; g < CHROM_W/GENE_W; g++) s += int'(c[CHROM_W-1-GENE_W*g -: GENE_W]);
        return s;
    endfunction

    function automatic logic [POP_W-1:0] make_pop(input int kind);
        logic [POP_W-1:0] p;
        p = '0;
        case (kind)
            1: p = '1;
            2: p[POP_W-1-CHROM_W*137 -: CHROM_W] = {5'd31, 5'd31, 5'd0, 5'd0, 5'd1, 5'd2};
            3: begin
                p[POP_W-1-CHROM_W*10  -: CHROM_W] = {5'd31, 5'd31, 5'd31, 5'd7, 5'd0, 5'd0};
                p[POP_W-1-CHROM_W*200 -: CHROM_W] = {5'd7, 5'd31, 5'd0, 5'd31, 5'd0, 5'd31};
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    task automatic do_run(input logic [POP_W-1:0] pop, input int exp_bi, input int exp_bf,
                          input int exp_tot, input int n_runs, input bit extra_start,
                          input bit chg_pop);
        int cyc, ndone, nfv, d0, d1;
        exp_t e;
        population = pop;
        q.delete();
        for (int r = 0; r < n_runs; r++)
            for (int i = 0; i < NUM_CHROM; i++) q.push_back('{i, fit_of(pop, i)});
        @(negedge clk);
        start = 1'b1;
        cyc = 0; ndone = 0; nfv = 0; d0 = 0; d1 = 0;
        while (cyc < 253*n_runs + 12) begin
            @(posedge clk);
            #1;
            cyc++;
            if (n_runs == 1 && cyc == 1) start = 1'b0;
            if (extra_start) start = (cyc == 100 || cyc == 252);
            if (chg_pop && cyc == 2) population = ~pop;
            if (fit_valid) begin
                nfv++;
                if (q.size() == 0) begin
                    chk("extra_fit_valid", nfv, NUM_CHROM*n_runs);
                end else begin
                    e = q.pop_front();
                    if (fit_index != 8'(e.idx)) chk("fit_index", int'(fit_index), e.idx);
                    if (fit_value != 8'(e.val)) chk("fit_value", int'(fit_value), e.val);
                end
            end
            if (done) begin
                ndone++;
                if (ndone == 1) d0 = cyc; else d1 = cyc;
                if (ndone == n_runs) start = 1'b0;
                chk("best_index", int'(best_index), exp_bi);
                chk("best_fitness", int'(best_fitness), exp_bf);
                chk("total_fitness", int'(total_fitness), exp_tot);
            end
        end
        chk("done_count", ndone, n_runs);
        chk("done_latency", d0, 252);
        if (n_runs == 2) chk("done_spacing", d1 - d0, 253);
        chk("fit_valid_count", nfv, NUM_CHROM*n_runs);
        chk("queue_left", q.size(), 0);
        chk("busy_after", int'(busy), 0);
        chk("total_held", int'(total_fitness), exp_tot);
        chk("best_held", int'(best_index), exp_bi);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_fit_valid"}, int'(fit_valid), 0);
        chk({tag, "_fit_index"}, int'(fit_index), 0);
        chk({tag, "_fit_value"}, int'(fit_value), 0);
        chk({tag, "_best_index"}, int'(best_index), 0);
        chk({tag, "_best_fitness"}, int'(best_fitness), 0);
        chk({tag, "_total"}, int'(total_fitness), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        int cyc;
        bit seen;
        vecs[0] = '{0, 0, 0, 0};
        vecs[1] = '{1, 0, 186, 46500};
        vecs[2] = '{2, 137, 65, 65};
        vecs[3] = '{3, 10, 100, 200};

        rst = 1'b1; start = 1'b1; population = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        start = 1'b0;
        rst = 1'b0;

        for (int v = 0; v < 4; v++)
            do_run(make_pop(vecs[v].kind), vecs[v].bi, vecs[v].bf, vecs[v].tot, 1, 1'b0, 1'b0);

        // Reset mid-EVAL with the counter at 120.
        population = make_pop(2);
        @(negedge clk);
        start = 1'b1;
        cyc = 0; seen = 1'b0;
        while (cyc < 300 && !seen) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            if (fit_valid && fit_index == 8'd119) seen = 1'b1;
        end
        chk("reached_idx119", int'(seen), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("midrun_reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_after_reset", int'(busy), 0);
        do_run(make_pop(3), 10, 100, 200, 1, 1'b0, 1'b0);

        do_run(make_pop(2), 137, 65, 65, 1, 1'b1, 1'b0);
        do_run(make_pop(3), 10, 100, 200, 2, 1'b0, 1'b0);
        do_run(make_pop(2), 137, 65, 65, 1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
